// File: rtl/matmul_pkg.sv
// Shared types and sizes for the 2x2 matrix-multiply sequencer.
package matmul_pkg;

  localparam int ELEM_W  = 8;
  localparam int PROD_W  = 16;
  localparam int ACC_W   = 17;
  localparam int N_STEPS = 8;

  typedef logic [ELEM_W-1:0] elem_t;
  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [ACC_W-1:0]  acc_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mm_state_t;

  // Widen a raw product to accumulator width (upper bits are always zero)
  function automatic acc_t widen_prod(input prod_t p);
    return {{(ACC_W-PROD_W){1'b0}}, p};
  endfunction

endpackage

// File: rtl/matmul2x2_ctrl_if.sv
// Operand/result handshake bundle between the loader, the sequencer and the consumer.
interface matmul2x2_ctrl_if;
  import matmul_pkg::*;

  logic            in_valid;
  logic            in_ready;
  elem_t [3:0]     a_in;
  elem_t [3:0]     b_in;
  logic            out_valid;
  logic            out_ready;
  acc_t  [3:0]     c_out;
  logic            busy;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, c_out, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, c_out, busy
  );

endinterface

// File: rtl/adder16.sv
// 16-bit ripple-carry adder used as the final carry-propagate stage of the multiplier.
module adder16
  import matmul_pkg::*;
(
  input  prod_t a,
  input  prod_t b,
  input  logic  cin,
  output prod_t sum,
  output logic  cout
);

  logic c;

  // Ripple the carry bit by bit from LSB to MSB
  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < PROD_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/mul8x8.sv
// Combinational unsigned 8x8 array multiplier: AND-matrix, carry-save reduce, final add.
module mul8x8
  import matmul_pkg::*;
(
  input  elem_t a,
  input  elem_t b,
  output prod_t product
);

  logic [ELEM_W-1:0][ELEM_W-1:0] pp;
  prod_t                         red_sum;
  prod_t                         red_carry;
  logic                          unused_carry_out;

  // Partial product bit pp[i][j] carries weight 2^(i+j)
  always_comb begin
    pp = '0;
    for (int i = 0; i < ELEM_W; i++) begin
      for (int j = 0; j < ELEM_W; j++) begin
        pp[i][j] = a[i] & b[j];
      end
    end
  end

  reduce u_reduce (
    .pp    (pp),
    .m     ('0),
    .sum   (red_sum),
    .carry (red_carry)
  );

  // An 8x8 product never exceeds 16 bits, so the final carry-out is always zero
  adder16 u_adder16 (
    .a    (red_sum),
    .b    (red_carry),
    .cin  (1'b0),
    .sum  (product),
    .cout (unused_carry_out)
  );

endmodule

// File: rtl/reduce.sv
// Carry-save reduction of an 8x8 partial-product matrix (plus an extra addend row m)
// down to a sum row and a carry row.
module reduce
  import matmul_pkg::*;
(
  input  logic [ELEM_W-1:0][ELEM_W-1:0] pp,
  input  prod_t                         m,
  output prod_t                         sum,
  output prod_t                         carry
);

  prod_t sum_v;
  prod_t carry_v;
  prod_t row;
  prod_t tmp;

  // Fold each shifted partial-product row into the running sum/carry pair with a 3:2 compressor
  always_comb begin
    sum_v   = m;
    carry_v = '0;
    row     = '0;
    tmp     = '0;
    for (int i = 0; i < ELEM_W; i++) begin
      row     = PROD_W'(pp[i]) << i;
      tmp     = sum_v ^ carry_v ^ row;
      carry_v = ((sum_v & carry_v) | (sum_v & row) | (carry_v & row)) << 1;
      sum_v   = tmp;
    end
    sum   = sum_v;
    carry = carry_v;
  end

endmodule

// File: rtl/matmul2x2_ctrl.sv
// 2x2 by 2x2 unsigned matrix multiply sequencer: one shared 8x8 multiplier stepped
// over eight cycles, accumulating into four 17-bit result registers.
module matmul2x2_ctrl
  import matmul_pkg::*;
#(
  parameter bit REG_PRODUCT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  matmul2x2_ctrl_if.slave  bus
);

  mm_state_t   state;
  logic [2:0]  s;
  elem_t [3:0] a_reg;
  elem_t [3:0] b_reg;
  acc_t  [3:0] acc;
  logic        ready_reg;
  logic        valid_reg;
  logic        busy_reg;

  elem_t       mul_a;
  elem_t       mul_b;
  prod_t       product;
  prod_t       add_val;
  logic [1:0]  add_idx;
  logic        add_en;

  // Step s selects A[i][k] and B[k][j] with i = s[2], j = s[1], k = s[0]
  always_comb begin
    mul_a = a_reg[{s[2], s[0]}];
    mul_b = b_reg[{s[0], s[1]}];
  end

  mul8x8 u_mul (
    .a       (mul_a),
    .b       (mul_b),
    .product (product)
  );

  generate
    if (REG_PRODUCT) begin : g_prod_reg
      prod_t      prod_reg;
      logic [1:0] idx_reg;
      logic       prod_valid;

      // Retime the product and its destination index by one cycle to cut the multiplier path
      always_ff @(posedge clk) begin
        if (rst) begin
          prod_reg   <= '0;
          idx_reg    <= '0;
          prod_valid <= 1'b0;
        end else begin
          prod_reg   <= product;
          idx_reg    <= s[2:1];
          prod_valid <= (state == MUL);
        end
      end

      assign add_val = prod_reg;
      assign add_idx = idx_reg;
      assign add_en  = prod_valid;
    end else begin : g_prod_comb
      assign add_val = product;
      assign add_idx = s[2:1];
      assign add_en  = (state == MUL);
    end
  endgenerate

  // Main sequencer: accept a job, step the multiplier, optionally drain, then hold the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s         <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      ready_reg <= 1'b1;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && ready_reg) begin
            a_reg     <= bus.a_in;
            b_reg     <= bus.b_in;
            acc       <= '0;
            s         <= '0;
            state     <= MUL;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
          end
        end
        MUL: begin
          if (add_en) begin
            acc[add_idx] <= acc[add_idx] + widen_prod(add_val);
          end
          s <= s + 3'd1;
          if (s == 3'(N_STEPS - 1)) begin
            if (REG_PRODUCT) begin
              state <= DRAIN;
            end else begin
              state     <= DONE;
              valid_reg <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (add_en) begin
            acc[add_idx] <= acc[add_idx] + widen_prod(add_val);
          end
          state     <= DONE;
          valid_reg <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) begin
            state     <= IDLE;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          ready_reg <= 1'b1;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready_reg;
  assign bus.out_valid = valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.c_out     = acc;

endmodule

// File: tb/tb_matmul2x2_ctrl.sv
// Directed bench for matmul2x2_ctrl: runs the same job sequence against the
// combinational-product and registered-product variants.
module tb_matmul2x2_ctrl;
  import matmul_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sel = 1'b0;
  logic             in_valid_d = 1'b0;
  logic             out_ready_d = 1'b0;
  logic [3:0][7:0]  a_d = '0;
  logic [3:0][7:0]  b_d = '0;

  int checks = 0;
  int errors = 0;

  matmul2x2_ctrl_if bus0 ();
  matmul2x2_ctrl_if bus1 ();

  assign bus0.in_valid  = in_valid_d;
  assign bus0.out_ready = out_ready_d;
  assign bus0.a_in      = a_d;
  assign bus0.b_in      = b_d;
  assign bus1.in_valid  = in_valid_d;
  assign bus1.out_ready = out_ready_d;
  assign bus1.a_in      = a_d;
  assign bus1.b_in      = b_d;

  matmul2x2_ctrl #(.REG_PRODUCT(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  matmul2x2_ctrl #(.REG_PRODUCT(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  logic            in_ready_o;
  logic            out_valid_o;
  logic            busy_o;
  logic [3:0][16:0] c_o;

  assign in_ready_o  = sel ? bus1.in_ready  : bus0.in_ready;
  assign out_valid_o = sel ? bus1.out_valid : bus0.out_valid;
  assign busy_o      = sel ? bus1.busy      : bus0.busy;
  assign c_o         = sel ? bus1.c_out     : bus0.c_out;

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Hard stop in case a wait slips past its own bound
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got running required finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s (dut%0d) got %0d expected %0d", tag, sel, got, exp);
    end
  endtask

  function automatic logic [3:0][7:0] mat(input int e0, input int e1, input int e2, input int e3);
    mat = {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  task automatic checkMatrix(input string tag, input int c00, input int c01, input int c10, input int c11);
    checkOutput({tag, "_c00"}, int'(c_o[0]), c00);
    checkOutput({tag, "_c01"}, int'(c_o[1]), c01);
    checkOutput({tag, "_c10"}, int'(c_o[2]), c10);
    checkOutput({tag, "_c11"}, int'(c_o[3]), c11);
  endtask

  // Present a job and return just after the edge that accepts it
  task automatic applyStimulus(input logic [3:0][7:0] a, input logic [3:0][7:0] b);
    int n;
    n = 0;
    a_d = a;
    b_d = b;
    in_valid_d = 1'b1;
    while (!in_ready_o && n < 30) begin
      tick();
      n++;
    end
    checkOutput("accept", int'(in_ready_o), 1);
    tick();
    in_valid_d = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid_o && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic runSequence(input int lat_exp);
    int lat;

    rst = 1'b1;
    in_valid_d = 1'b1;
    out_ready_d = 1'b0;
    a_d = mat(1, 1, 1, 1);
    b_d = mat(1, 1, 1, 1);
    tick();
    tick();
    checkOutput("rst_out_valid", int'(out_valid_o), 0);
    checkOutput("rst_in_ready", int'(in_ready_o), 1);
    checkOutput("rst_busy", int'(busy_o), 0);
    checkMatrix("rst", 0, 0, 0, 0);
    rst = 1'b0;
    in_valid_d = 1'b0;
    tick();
    checkOutput("post_rst_busy", int'(busy_o), 0);

    applyStimulus(mat(1, 0, 0, 1), mat(9, 8, 7, 6));
    checkOutput("mul_busy", int'(busy_o), 1);
    checkOutput("mul_in_ready", int'(in_ready_o), 0);
    waitResult(lat);
    checkOutput("identity_latency", lat, lat_exp);
    checkMatrix("identity", 9, 8, 7, 6);

    in_valid_d = 1'b1;
    a_d = mat(3, 3, 3, 3);
    b_d = mat(3, 3, 3, 3);
    for (int n = 0; n < 5; n++) begin
      tick();
      checkOutput("bp_out_valid", int'(out_valid_o), 1);
      checkOutput("bp_in_ready", int'(in_ready_o), 0);
      checkOutput("bp_c00", int'(c_o[0]), 9);
      checkOutput("bp_c11", int'(c_o[3]), 6);
    end
    in_valid_d = 1'b0;
    out_ready_d = 1'b1;
    tick();
    out_ready_d = 1'b0;
    checkOutput("release_out_valid", int'(out_valid_o), 0);
    checkOutput("release_in_ready", int'(in_ready_o), 1);
    checkOutput("release_busy", int'(busy_o), 0);
    checkMatrix("hold", 9, 8, 7, 6);

    applyStimulus(mat(1, 2, 3, 4), mat(5, 6, 7, 8));
    waitResult(lat);
    checkOutput("general_latency", lat, lat_exp);
    checkMatrix("general", 19, 22, 43, 50);
    out_ready_d = 1'b1;
    tick();

    applyStimulus(mat(255, 255, 255, 255), mat(255, 255, 255, 255));
    waitResult(lat);
    checkOutput("max_latency", lat, lat_exp);
    checkMatrix("max", 130050, 130050, 130050, 130050);
    tick();
    checkOutput("max_release_in_ready", int'(in_ready_o), 1);

    a_d = mat(1, 2, 3, 4);
    b_d = mat(5, 6, 7, 8);
    in_valid_d = 1'b1;
    tick();
    a_d = mat(255, 0, 0, 255);
    b_d = mat(2, 3, 4, 5);
    waitResult(lat);
    checkOutput("b2b_first_latency", lat, lat_exp);
    checkMatrix("b2b_first", 19, 22, 43, 50);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid_o && lat < 40);
    checkOutput("b2b_period", lat, lat_exp + 2);
    checkMatrix("b2b_second", 510, 765, 1020, 1275);
    in_valid_d = 1'b0;
    tick();
    out_ready_d = 1'b0;

    applyStimulus(mat(1, 2, 3, 4), mat(5, 6, 7, 8));
    repeat (4) tick();
    checkOutput("pre_rst_c00", int'(c_o[0]), 19);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", int'(busy_o), 0);
    checkOutput("midrst_in_ready", int'(in_ready_o), 1);
    checkOutput("midrst_out_valid", int'(out_valid_o), 0);
    checkMatrix("midrst", 0, 0, 0, 0);

    applyStimulus(mat(1, 0, 0, 1), mat(9, 8, 7, 6));
    waitResult(lat);
    checkOutput("fresh_latency", lat, lat_exp);
    checkMatrix("fresh", 9, 8, 7, 6);
    out_ready_d = 1'b1;
    tick();
    out_ready_d = 1'b0;
  endtask

  // Exercise the combinational-product variant, then the registered-product variant
  initial begin
    sel = 1'b0;
    $display("[TB] REG_PRODUCT=0 sequence");
    runSequence(8);
    sel = 1'b1;
    $display("[TB] REG_PRODUCT=1 sequence");
    runSequence(9);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul2x2_ctrl.md
# matmul2x2_ctrl

Sequencer that computes a 2×2 × 2×2 unsigned 8-bit matrix product, C = A·B, by time-multiplexing a single shared 8×8 array multiplier (partial-product build, `reduce`, `adder16`) over eight cycles and accumulating into four 17-bit result registers. It sits between the operand-loading front end and the result consumer. It exposes a valid/ready handshake on both sides, so upstream and downstream logic can stall it freely.

## Interface
- `REG_PRODUCT`, default 0: 1 inserts a register on the multiplier output. This adds one cycle of latency and shortens the critical path.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: operand set valid.
- `in_ready` out 1: block can accept operands.
- `a_in` in 4×8: A elements, row-major [0]=a00, [1]=a01, [2]=a10, [3]=a11.
- `b_in` in 4×8: B elements, row-major.
- `out_valid` out 1: `c_out` holds a complete result.
- `out_ready` in 1: consumer accepts result.
- `c_out` out 4×17: C elements, row-major, unsigned.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - MUL: 8 steps, driven by a 3-bit step counter `s`.
  - DRAIN: only when `REG_PRODUCT`=1; one cycle to accumulate the final registered product.
  - DONE: `out_valid`=1.
- Transitions:
  - IDLE → MUL on `in_valid && in_ready`. In that cycle: latch `a_in`/`b_in` into operand registers, clear all four accumulators, set `s`=0.
  - MUL: each cycle `s` increments. After `s`=7, go to DONE, or to DRAIN if `REG_PRODUCT`=1.
  - DRAIN → DONE unconditionally.
  - DONE → IDLE on `out_ready`.
- Step decode: idx=`s`[2:1], i=idx[1], j=idx[0], k=`s`[0].
  - Multiplier operands: A[i][k], B[k][j].
  - The product (16 bits; `adder16` carry-out is always 0 for 8×8) is zero-extended to 17 bits and added to acc[idx].
  - With `REG_PRODUCT`=1, the product computed at step `s` is added one cycle later. The idx must be delayed with it.
- Width: max element is 2·255·255 = 130050 < 2^17, so no overflow is possible and none is checked.
- `c_out` is driven directly by the accumulators. It is stable while `out_valid`=1 and holds its last value after the handshake, until the next acceptance clears it.
- Input is not accepted while busy. `in_ready`=0 in MUL, DRAIN and DONE, so there is no overlap between jobs.
- `out_ready` asserted outside DONE has no effect.

## Timing
- Reset values: state=IDLE, `s`=0, all accumulators=0, `c_out`=0, `out_valid`=0, `in_ready`=1 (the cycle after reset deasserts), `busy`=0.
- Latency: acceptance at edge T gives `out_valid`=1 after edge T+8, or T+9 with `REG_PRODUCT`=1.
- Minimum job period is 10 cycles (11 with `REG_PRODUCT`=1) when `out_ready` is held high. IDLE costs one cycle between jobs.
- `rst` asserted mid-MUL or in DONE: the next state is IDLE with all registers at reset values. The partial result is discarded and no `out_valid` pulse is produced.
- `in_valid` high during reset is ignored.
- The multiplier path is combinational from operand registers plus `s` to the accumulator D input. It must close timing at one cycle when `REG_PRODUCT`=0.

## Structure
- Package `matmul_pkg`:
  - State enum `mm_state_t` (IDLE, MUL, DRAIN, DONE).
  - `ELEM_W`=8, `PROD_W`=16, `ACC_W`=17, `N_STEPS`=8.
  - Typedefs `elem_t`, `acc_t`.
- Sub-module `mul8x8`: builds P[i][j]=a[i]&b[j], instantiates the existing `reduce` (M tied to 0) and `adder16`, and outputs a 16-bit product. It is purely combinational and is instantiated exactly once in `matmul2x2_ctrl`.

## Test plan
- Identity: A=[[1,0],[0,1]], B=[[9,8],[7,6]] → C=[[9,8],[7,6]]. `out_valid` rises exactly 8 cycles after acceptance (9 with `REG_PRODUCT`=1).
- General: A=[[1,2],[3,4]], B=[[5,6],[7,8]] → C=[[19,22],[43,50]].
- Max: all elements 255 → every C element = 130050 (0x1FC02). This exercises full width.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid`. `c_out` stays stable, `in_ready`=0, and `in_valid` is ignored. Raise `out_ready` → IDLE next cycle.
- Back-to-back: two jobs with `in_valid` and `out_ready` held high. Second result A=[[255,0],[0,255]], B=[[2,3],[4,5]] → [[510,765],[1020,1275]]. Job period is 10 cycles.
- Reset mid-op: assert `rst` on step 4 → next cycle IDLE, `c_out`=0, `out_valid`=0, `in_ready`=1. A fresh job then completes correctly.
